// File: rtl/e1_line_pkg.sv
// Shared constants, FSM state type and helpers for the E1 line controller.
package e1_line_pkg;

  localparam logic [1:0] LB_NORM   = 2'b00;
  localparam logic [1:0] LB_LOCAL  = 2'b01;
  localparam logic [1:0] LB_REMOTE = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_GUARD = 1'b1
  } state_e;

  localparam int DEF_LOS_SET   = 32;
  localparam int DEF_LOS_WIN   = 32;
  localparam int DEF_LOS_ONES  = 12;
  localparam int DEF_AIS_WIN   = 512;
  localparam int DEF_GUARD_CYC = 64;

  // The reserved loopback code 11 behaves as normal operation.
  function automatic logic [1:0] lb_norm(input logic [1:0] lb);
    return (lb == 2'b11) ? LB_NORM : lb;
  endfunction

endpackage

// File: rtl/e1_los_mon.sv
// Loss-of-signal monitor: zero-run counter asserts los, a free-running mark
// window while los is asserted clears it.
module e1_los_mon
  import e1_line_pkg::*;
#(
  parameter int LOS_SET  = DEF_LOS_SET,
  parameter int LOS_WIN  = DEF_LOS_WIN,
  parameter int LOS_ONES = DEF_LOS_ONES
) (
  input  logic clk2,
  input  logic rst,
  input  logic mark,
  output logic los
);

  localparam int ZW = $clog2(LOS_SET + 1);
  localparam int WW = (LOS_WIN > 1) ? $clog2(LOS_WIN) : 1;
  localparam int MW = $clog2(LOS_WIN + 1);

  localparam logic [ZW-1:0] ZR_MAX   = ZW'(LOS_SET);
  localparam logic [WW-1:0] WIN_LAST = WW'(LOS_WIN - 1);
  localparam logic [MW-1:0] MK_ONES  = MW'(LOS_ONES);

  logic [ZW-1:0] zr_q, zr_d;
  logic [WW-1:0] win_q, win_d;
  logic [MW-1:0] mk_q, mk_d, mk_tot;
  logic          los_q, los_d;

  always_comb begin
    zr_d   = zr_q;
    win_d  = win_q;
    mk_d   = mk_q;
    los_d  = los_q;
    mk_tot = mk_q + {{(MW-1){1'b0}}, mark};

    if (mark) begin
      zr_d = '0;
    end else if (zr_q != ZR_MAX) begin
      zr_d = zr_q + 1'b1;
    end

    // Set is only evaluated while clear, clear only while set.
    if (!los_q) begin
      win_d = '0;
      mk_d  = '0;
      if (zr_d == ZR_MAX) begin
        los_d = 1'b1;
      end
    end else if (win_q == WIN_LAST) begin
      win_d = '0;
      mk_d  = '0;
      if (mk_tot >= MK_ONES) begin
        los_d = 1'b0;
      end
    end else begin
      win_d = win_q + 1'b1;
      mk_d  = mk_tot;
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      zr_q  <= '0;
      win_q <= '0;
      mk_q  <= '0;
      los_q <= 1'b1;
    end else begin
      zr_q  <= zr_d;
      win_q <= win_d;
      mk_q  <= mk_d;
      los_q <= los_d;
    end
  end

  assign los = los_q;

endmodule

// File: rtl/e1_line_ctrl.sv
// E1 HDB3 codec line controller: data muxing, guarded mode/loopback changes,
// LOS/AIS monitoring, transmit AIS. Optional macro E1_LINE_ILLEGAL_CNT_EN.
module e1_line_ctrl
  import e1_line_pkg::*;
#(
  parameter int LOS_SET   = DEF_LOS_SET,
  parameter int LOS_WIN   = DEF_LOS_WIN,
  parameter int LOS_ONES  = DEF_LOS_ONES,
  parameter int AIS_WIN   = DEF_AIS_WIN,
  parameter int GUARD_CYC = DEF_GUARD_CYC
) (
  input  logic       clk2,
  input  logic       rst,
  input  logic       rpos,
  input  logic       rneg,
  input  logic       ser_rx,
  input  logic       fr_tx,
  output logic       fr_rx,
  output logic       hdb_serin,
  output logic       hdb_nrzmode,
  input  logic       cfg_nrz,
  input  logic [1:0] cfg_lb,
  input  logic       cfg_ais_tx,
  input  logic       cfg_auto_ais,
  output logic       los,
  output logic       ais_det,
  output logic [1:0] lb_active,
  output logic       busy,
  input  logic       cnt_clr
`ifdef E1_LINE_ILLEGAL_CNT_EN
  ,output logic [15:0] illegal_cnt
`endif
);

  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int AW = (AIS_WIN > 1) ? $clog2(AIS_WIN) : 1;

  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC - 1);
  localparam logic [AW-1:0] AIS_LAST   = AW'(AIS_WIN - 1);

  state_e      state_q, state_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic        tgt_nrz_q, tgt_nrz_d;
  logic [1:0]  tgt_lb_q, tgt_lb_d;
  logic        nrz_q, nrz_d;
  logic [1:0]  lb_q, lb_d;
  logic        busy_q, busy_d;
  logic        fr_rx_q, fr_rx_d;
  logic        serin_q, serin_d;
  logic [1:0]  req_lb;
  logic        ais_tx;
  logic        mark;
  logic        los_w;

  assign req_lb = lb_norm(cfg_lb);

  always_comb begin
    state_d   = state_q;
    gcnt_d    = gcnt_q;
    tgt_nrz_d = tgt_nrz_q;
    tgt_lb_d  = tgt_lb_q;
    nrz_d     = nrz_q;
    lb_d      = lb_q;
    busy_d    = busy_q;

    unique case (state_q)
      ST_RUN: begin
        if ({cfg_nrz, req_lb} != {nrz_q, lb_q}) begin
          state_d   = ST_GUARD;
          gcnt_d    = GUARD_LOAD;
          tgt_nrz_d = cfg_nrz;
          tgt_lb_d  = req_lb;
          busy_d    = 1'b1;
        end
      end
      ST_GUARD: begin
        // A new request mid-guard restarts the full AIS interval.
        if ({cfg_nrz, req_lb} != {tgt_nrz_q, tgt_lb_q}) begin
          gcnt_d    = GUARD_LOAD;
          tgt_nrz_d = cfg_nrz;
          tgt_lb_d  = req_lb;
        end else if (gcnt_q == '0) begin
          nrz_d   = tgt_nrz_q;
          lb_d    = tgt_lb_q;
          busy_d  = 1'b0;
          state_d = ST_RUN;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Output registers follow the mode that is applied in the same cycle.
  always_comb begin
    ais_tx  = cfg_ais_tx | (cfg_auto_ais & los_w);
    serin_d = busy_d | ais_tx | ((lb_d == LB_REMOTE) ? ser_rx : fr_tx);
    fr_rx_d = busy_d | ((lb_d == LB_LOCAL) ? fr_tx : ser_rx);
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q   <= ST_RUN;
      gcnt_q    <= '0;
      tgt_nrz_q <= 1'b0;
      tgt_lb_q  <= LB_NORM;
      nrz_q     <= 1'b0;
      lb_q      <= LB_NORM;
      busy_q    <= 1'b0;
      fr_rx_q   <= 1'b1;
      serin_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      gcnt_q    <= gcnt_d;
      tgt_nrz_q <= tgt_nrz_d;
      tgt_lb_q  <= tgt_lb_d;
      nrz_q     <= nrz_d;
      lb_q      <= lb_d;
      busy_q    <= busy_d;
      fr_rx_q   <= fr_rx_d;
      serin_q   <= serin_d;
    end
  end

  // In NRZ bypass only rpos carries data.
  assign mark = nrz_q ? rpos : (rpos | rneg);

  e1_los_mon #(
    .LOS_SET  (LOS_SET),
    .LOS_WIN  (LOS_WIN),
    .LOS_ONES (LOS_ONES)
  ) u_los_mon (
    .clk2 (clk2),
    .rst  (rst),
    .mark (mark),
    .los  (los_w)
  );

  logic [AW-1:0] aw_q, aw_d;
  logic [1:0]    az_q, az_d, az_tot;
  logic          ais_q, ais_d;

  always_comb begin
    aw_d  = aw_q;
    az_d  = az_q;
    ais_d = ais_q;
    az_tot = (ser_rx || az_q == 2'd3) ? az_q : az_q + 2'd1;
    if (aw_q == AIS_LAST) begin
      aw_d  = '0;
      az_d  = '0;
      ais_d = (az_tot < 2'd3);
    end else begin
      aw_d = aw_q + 1'b1;
      az_d = az_tot;
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      aw_q  <= '0;
      az_q  <= '0;
      ais_q <= 1'b0;
    end else begin
      aw_q  <= aw_d;
      az_q  <= az_d;
      ais_q <= ais_d;
    end
  end

`ifdef E1_LINE_ILLEGAL_CNT_EN
  logic [15:0] il_q, il_d;

  always_comb begin
    il_d = il_q;
    if (cnt_clr) begin
      il_d = '0;
    end else if (rpos && rneg && !nrz_q && il_q != 16'hFFFF) begin
      il_d = il_q + 16'd1;
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      il_q <= '0;
    end else begin
      il_q <= il_d;
    end
  end

  assign illegal_cnt = il_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
`endif

  assign fr_rx       = fr_rx_q;
  assign hdb_serin   = serin_q;
  assign hdb_nrzmode = nrz_q;
  assign lb_active   = lb_q;
  assign busy        = busy_q;
  assign los         = los_w;
  assign ais_det     = ais_q;

endmodule

// File: tb/tb_e1_line_ctrl.sv
// Randomized self-checking bench for e1_line_ctrl against a behavioural model.
`timescale 1ns/1ps
module tb_e1_line_ctrl;

  localparam int LOS_SET   = 32;
  localparam int LOS_WIN   = 32;
  localparam int LOS_ONES  = 12;
  localparam int AIS_WIN   = 512;
  localparam int GUARD_CYC = 64;

  logic       clk2 = 1'b0;
  logic       rst;
  logic       rpos, rneg, ser_rx, fr_tx;
  logic       fr_rx, hdb_serin, hdb_nrzmode;
  logic       cfg_nrz, cfg_ais_tx, cfg_auto_ais, cnt_clr;
  logic [1:0] cfg_lb;
  logic       los, ais_det, busy;
  logic [1:0] lb_active;
`ifdef E1_LINE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt;
`endif

  always #5 clk2 = ~clk2;

  e1_line_ctrl dut (
    .clk2         (clk2),
    .rst          (rst),
    .rpos         (rpos),
    .rneg         (rneg),
    .ser_rx       (ser_rx),
    .fr_tx        (fr_tx),
    .fr_rx        (fr_rx),
    .hdb_serin    (hdb_serin),
    .hdb_nrzmode  (hdb_nrzmode),
    .cfg_nrz      (cfg_nrz),
    .cfg_lb       (cfg_lb),
    .cfg_ais_tx   (cfg_ais_tx),
    .cfg_auto_ais (cfg_auto_ais),
    .los          (los),
    .ais_det      (ais_det),
    .lb_active    (lb_active),
    .busy         (busy),
    .cnt_clr      (cnt_clr)
`ifdef E1_LINE_ILLEGAL_CNT_EN
    ,.illegal_cnt (illegal_cnt)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit         m_los, m_ais, m_guard, m_serin, m_frrx, m_nrz;
  logic [1:0] m_lb;
  logic [2:0] m_tgt;
  int         m_zrun, m_wbits, m_wmarks, m_abits, m_azeros, m_remain, m_ill;

  task automatic model_reset();
    m_los = 1; m_ais = 0; m_guard = 0; m_serin = 1; m_frrx = 1; m_nrz = 0;
    m_lb = 2'b00; m_tgt = 3'b000;
    m_zrun = 0; m_wbits = 0; m_wmarks = 0; m_abits = 0; m_azeros = 0;
    m_remain = 0; m_ill = 0;
  endtask

  task automatic step();
    bit         mark, los_prev, ais_tx;
    logic [2:0] req;
    @(posedge clk2);
    mark     = m_nrz ? rpos : (rpos | rneg);
    los_prev = m_los;

    m_zrun = mark ? 0 : ((m_zrun < LOS_SET) ? m_zrun + 1 : m_zrun);
    if (!m_los) begin
      m_wbits = 0; m_wmarks = 0;
      if (m_zrun >= LOS_SET) m_los = 1;
    end else begin
      m_wbits++;
      if (mark) m_wmarks++;
      if (m_wbits == LOS_WIN) begin
        if (m_wmarks >= LOS_ONES) m_los = 0;
        m_wbits = 0; m_wmarks = 0;
      end
    end

    m_abits++;
    if (!ser_rx) m_azeros++;
    if (m_abits == AIS_WIN) begin
      m_ais = (m_azeros < 3);
      m_abits = 0; m_azeros = 0;
    end

    if (cnt_clr) m_ill = 0;
    else if (rpos && rneg && !m_nrz && m_ill < 65535) m_ill++;

    req = {cfg_nrz, (cfg_lb == 2'b11) ? 2'b00 : cfg_lb};
    if (!m_guard) begin
      if (req != {m_nrz, m_lb}) begin
        m_guard = 1; m_remain = GUARD_CYC; m_tgt = req;
      end
    end else if (req != m_tgt) begin
      m_remain = GUARD_CYC; m_tgt = req;
    end else begin
      m_remain--;
      if (m_remain == 0) begin
        m_nrz = m_tgt[2]; m_lb = m_tgt[1:0]; m_guard = 0;
      end
    end

    ais_tx = cfg_ais_tx || (cfg_auto_ais && los_prev);
    if (m_guard || ais_tx) m_serin = 1;
    else m_serin = (m_lb == 2'b10) ? ser_rx : fr_tx;
    if (m_guard) m_frrx = 1;
    else m_frrx = (m_lb == 2'b01) ? fr_tx : ser_rx;

    #1;
    check("los",       32'(los),         32'(m_los));
    check("ais_det",   32'(ais_det),     32'(m_ais));
    check("busy",      32'(busy),        32'(m_guard));
    check("lb_active", 32'(lb_active),   32'(m_lb));
    check("nrzmode",   32'(hdb_nrzmode), 32'(m_nrz));
    check("hdb_serin", 32'(hdb_serin),   32'(m_serin));
    check("fr_rx",     32'(fr_rx),       32'(m_frrx));
`ifdef E1_LINE_ILLEGAL_CNT_EN
    check("illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
`endif
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && busy; i++) step();
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int         cnt, p1, p2, p3, dens;
    logic       v;
    rst = 1; rpos = 0; rneg = 0; ser_rx = 1; fr_tx = 0;
    cfg_nrz = 0; cfg_lb = 2'b00; cfg_ais_tx = 0; cfg_auto_ais = 0; cnt_clr = 0;
    repeat (3) @(posedge clk2);
    #1;
    check("rst_fr_rx",   32'(fr_rx),       32'd1);
    check("rst_serin",   32'(hdb_serin),   32'd1);
    check("rst_nrzmode", 32'(hdb_nrzmode), 32'd0);
    check("rst_los",     32'(los),         32'd1);
    check("rst_ais",     32'(ais_det),     32'd0);
    check("rst_lb",      32'(lb_active),   32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    model_reset();
    rst = 0;

    // LOS: no marks keeps los, marks clear it at a window end, 32 zeros set it
    repeat (31) begin
      ser_rx = 1'($urandom); fr_tx = 1'($urandom); step();
    end
    check("los_hold", 32'(los), 32'd1);
    repeat (64) begin
      rpos = 1'($urandom); rneg = ~rpos;
      ser_rx = 1'($urandom); fr_tx = 1'($urandom); step();
    end
    check("los_clear", 32'(los), 32'd0);
    rpos = 0; rneg = 0;
    repeat (31) step();
    check("los_31_zeros", 32'(los), 32'd0);
    step();
    check("los_32_zeros", 32'(los), 32'd1);

    // AIS detection on aligned 512-bit windows
    for (int i = 0; i < AIS_WIN && m_abits != 0; i++) begin
      ser_rx = 1; step();
    end
    p1 = $urandom_range(0, 300);
    p2 = p1 + 1 + $urandom_range(0, 99);
    p3 = p2 + 1 + $urandom_range(0, 99);
    for (int i = 0; i < AIS_WIN; i++) begin
      ser_rx = !(i == p1 || i == p2); fr_tx = 1'($urandom); step();
    end
    check("ais_two_zeros", 32'(ais_det), 32'd1);
    for (int i = 0; i < AIS_WIN; i++) begin
      ser_rx = !(i == p1 || i == p2 || i == p3); fr_tx = 1'($urandom); step();
    end
    check("ais_three_zeros", 32'(ais_det), 32'd0);

    // Remote loopback with exactly GUARD_CYC AIS bits
    cfg_lb = 2'b10; cnt = 0;
    repeat (70) begin
      ser_rx = 1'($urandom); fr_tx = 1'($urandom); step();
      if (busy) cnt++;
    end
    check("guard_len", 32'(cnt), 32'd64);
    check("lb_remote", 32'(lb_active), 32'd2);
    repeat (4) begin
      v = 1'($urandom); ser_rx = v; fr_tx = ~v; step();
      check("serin_follows_rx", 32'(hdb_serin), 32'(v));
    end

    // Retarget at guard cycle 40 restarts the interval
    cfg_lb = 2'b01; cnt = 0;
    repeat (40) begin
      ser_rx = 1'($urandom); fr_tx = 1'($urandom); step();
      if (busy) cnt++;
    end
    cfg_lb = 2'b00;
    repeat (80) begin
      ser_rx = 1'($urandom); fr_tx = 1'($urandom); step();
      if (busy) cnt++;
    end
    check("guard_retarget_len", 32'(cnt), 32'd104);
    check("lb_normal", 32'(lb_active), 32'd0);

    // Automatic transmit AIS while los
    cfg_auto_ais = 1; fr_tx = 0;
    repeat (3) step();
    check("auto_ais_los", 32'(los), 32'd1);
    check("auto_ais_serin", 32'(hdb_serin), 32'd1);
    rpos = 1; rneg = 0;
    for (int i = 0; i < 100 && los; i++) step();
    check("auto_ais_los_cleared", 32'(los), 32'd0);
    repeat (4) begin
      v = 1'($urandom); fr_tx = v; step();
      check("serin_follows_tx", 32'(hdb_serin), 32'(v));
    end

    // Random traffic with occasional configuration changes
    dens = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) dens = $urandom_range(0, 3);
      case (dens)
        0: begin rpos = 0; rneg = 0; end
        1: begin rpos = ($urandom_range(0, 7) == 0); rneg = ($urandom_range(0, 7) == 0); end
        2: begin rpos = ($urandom_range(0, 2) == 0); rneg = ($urandom_range(0, 2) == 0); end
        default: begin rpos = 1'($urandom); rneg = 1'($urandom); end
      endcase
      ser_rx = ($urandom_range(0, 199) != 0);
      fr_tx = 1'($urandom);
      if ($urandom_range(0, 149) == 0) cfg_lb = 2'($urandom);
      if ($urandom_range(0, 199) == 0) cfg_nrz = ~cfg_nrz;
      if ($urandom_range(0, 99) == 0) cfg_ais_tx = ~cfg_ais_tx;
      if ($urandom_range(0, 99) == 0) cfg_auto_ais = ~cfg_auto_ais;
      cnt_clr = ($urandom_range(0, 63) == 0);
      step();
    end

    cfg_lb = 2'b00; cfg_nrz = 0; cfg_ais_tx = 0; cfg_auto_ais = 0; cnt_clr = 0;
    rpos = 0; rneg = 0;
    wait_idle("idle_after_random");

`ifdef E1_LINE_ILLEGAL_CNT_EN
    cnt_clr = 1; step(); cnt_clr = 0;
    rpos = 1; rneg = 1;
    repeat (5) step();
    rpos = 0; rneg = 0;
    check("illegal_five", 32'(illegal_cnt), 32'd5);
    cnt_clr = 1; rpos = 1; rneg = 1; step();
    check("illegal_clr_wins", 32'(illegal_cnt), 32'd0);
    cnt_clr = 0; rpos = 0; rneg = 0; cfg_nrz = 1;
    step();
    wait_idle("idle_nrz");
    rpos = 1; rneg = 1;
    repeat (5) step();
    rpos = 0; rneg = 0;
    check("illegal_nrz", 32'(illegal_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
